// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants, FSM encoding and helpers for the instruction-fetch stage
package if_fetch_pkg;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [2:0]  BYTES_PER_INST = 3'd4;
  localparam logic [2:0]  LAST_BYTE      = 3'd3;
  localparam logic [31:0] INST_STRIDE    = 32'd4;

  // Encodings are visible to IF/ID and the pipeline controller through this package.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - byte memory port and IF/ID hand-off bundle of the fetch stage
interface if_fetch_if;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_grant_i,
    input  mem_data_i,
    output inst_o,
    output pc_o,
    output inst_valid_o
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_grant_i,
    output mem_data_i,
    input  inst_o,
    input  pc_o,
    input  inst_valid_o
  );

endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V fetch stage: assembles 32-bit instructions from four byte reads
// and hands them to IF/ID, honouring redirects, stalls and the global ready.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        br_en_i,
  input  logic [31:0] br_target_i,
  if_fetch_if.master  bus
);

  fetch_state_t state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [2:0]   issue_cnt_q, issue_cnt_n;
  logic [2:0]   recv_cnt_q, recv_cnt_n;
  logic         pending_q, pending_n;
  logic [23:0]  byte_buf_q, byte_buf_n;
  logic [31:0]  inst_q, inst_n;
  logic [31:0]  inst_pc_q, inst_pc_n;
  logic         valid_q, valid_n;

  logic         mem_req;
  logic         issue_ok;

  // Request is decoded from registered state; reset also silences it so the port is
  // quiet while rst is high.
  assign mem_req  = rdy && !rst && (state_q == FETCH) && (issue_cnt_q < BYTES_PER_INST);
  assign issue_ok = mem_req && bus.mem_grant_i;

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = mem_req ? (pc_q + {29'b0, issue_cnt_q}) : ZERO_WORD;
  assign bus.inst_o       = inst_q;
  assign bus.pc_o         = inst_pc_q;
  assign bus.inst_valid_o = valid_q;

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    issue_cnt_n = issue_cnt_q;
    recv_cnt_n  = recv_cnt_q;
    pending_n   = pending_q;
    byte_buf_n  = byte_buf_q;
    inst_n      = inst_q;
    inst_pc_n   = inst_pc_q;
    valid_n     = valid_q;

    if (br_en_i) begin
      // Redirect wins over everything below; the byte still in flight is orphaned
      // by clearing pending.
      state_n     = FETCH;
      pc_n        = word_align(br_target_i);
      issue_cnt_n = 3'd0;
      recv_cnt_n  = 3'd0;
      pending_n   = DISABLE;
      valid_n     = DISABLE;
      inst_n      = ZERO_WORD;
      inst_pc_n   = ZERO_WORD;
    end else begin
      case (state_q)
        FETCH: begin
          if (issue_ok) begin
            issue_cnt_n = issue_cnt_q + 3'd1;
            pending_n   = ENABLE;
          end else begin
            pending_n   = DISABLE;
          end

          if (pending_q) begin
            recv_cnt_n = recv_cnt_q + 3'd1;
            case (recv_cnt_q)
              3'd0: byte_buf_n[7:0]   = bus.mem_data_i;
              3'd1: byte_buf_n[15:8]  = bus.mem_data_i;
              3'd2: byte_buf_n[23:16] = bus.mem_data_i;
              default: ;
            endcase
            // The top byte goes straight into the output word instead of the buffer.
            if (recv_cnt_q == LAST_BYTE) begin
              state_n   = HOLD;
              valid_n   = ENABLE;
              inst_n    = {bus.mem_data_i, byte_buf_q};
              inst_pc_n = pc_q;
            end
          end
        end

        HOLD: begin
          if (!stall_i) begin
            state_n     = FETCH;
            pc_n        = pc_q + INST_STRIDE;
            issue_cnt_n = 3'd0;
            recv_cnt_n  = 3'd0;
            pending_n   = DISABLE;
            valid_n     = DISABLE;
            inst_n      = ZERO_WORD;
            inst_pc_n   = ZERO_WORD;
          end
        end

        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      pending_q   <= DISABLE;
      byte_buf_q  <= 24'h0;
      inst_q      <= ZERO_WORD;
      inst_pc_q   <= ZERO_WORD;
      valid_q     <= DISABLE;
    end else if (rdy) begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      issue_cnt_q <= issue_cnt_n;
      recv_cnt_q  <= recv_cnt_n;
      pending_q   <= pending_n;
      byte_buf_q  <= byte_buf_n;
      inst_q      <= inst_n;
      inst_pc_q   <= inst_pc_n;
      valid_q     <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for the fetch stage against a byte-wide memory model
module tb_if_fetch;

  logic        dclk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        br_en_i;
  logic [31:0] br_target_i;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .dclk        (dclk),
    .rst         (rst),
    .rdy         (rdy),
    .stall_i     (stall_i),
    .br_en_i     (br_en_i),
    .br_target_i (br_target_i),
    .bus         (bus)
  );

  always #5 dclk = ~dclk;

  logic [7:0] mem [0:511];
  logic [7:0] rdata = 8'h00;

  always @(posedge dclk)
    if (bus.mem_req_o && bus.mem_grant_i) rdata <= mem[bus.mem_addr_o[8:0]];
  assign bus.mem_data_i = rdata;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[a[8:0] + 9'd3], mem[a[8:0] + 9'd2], mem[a[8:0] + 9'd1], mem[a[8:0]]};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = word_at(pc);
    return e;
  endfunction

  // Monitor: each new instruction is popped against the scoreboard; idle outputs must be 0.
  logic prev_valid = 1'b0;
  always @(negedge dclk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.inst_valid_o && !prev_valid) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_pc", 64'(bus.pc_o), 64'(e.pc));
          check("sb_inst", 64'(bus.inst_o), 64'(e.inst));
        end
      end else if (!bus.inst_valid_o) begin
        check("idle_zero", {bus.pc_o, bus.inst_o}, 64'd0);
      end
      prev_valid = bus.inst_valid_o;
    end
  end

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
    check(tag, {31'd0, bus.mem_req_o, bus.mem_addr_o}, {31'd0, req, addr});
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; br_en_i = 1'b0; br_target_i = 32'h0;
    bus.mem_grant_i = 1'b1;
    repeat (2) @(posedge dclk);
    #1;
    check("rst_valid", 64'(bus.inst_valid_o), 64'd0);
    check("rst_out", {bus.pc_o, bus.inst_o}, 64'd0);
    chk_bus("rst_bus", 1'b0, 32'h0);
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;

    // Basic fetch, stall hold and release.
    do_reset();
    sb.push_back(mk(32'h0));
    for (int c = 0; c <= 16; c++) begin
      stall_i = (c >= 5 && c <= 8);
      @(negedge dclk);
      if (c <= 3) chk_bus("s1_addr", 1'b1, 32'(c));
      if (c >= 4 && c <= 9) chk_bus("s1_idle", 1'b0, 32'h0);
      if (c >= 5 && c <= 9) begin
        check("s1_valid", 64'(bus.inst_valid_o), 64'd1);
        check("s1_inst", {bus.pc_o, bus.inst_o}, {32'h0, 32'h0000_0513});
      end
      if (c == 10) begin
        chk_bus("s1_next", 1'b1, 32'h4);
        sb.push_back(mk(32'h4));
      end
      if (c == 14) check("s1_v14", 64'(bus.inst_valid_o), 64'd0);
      if (c == 15) check("s1_v15", 64'(bus.inst_valid_o), 64'd1);
      if (c == 16) chk_bus("s1_addr8", 1'b1, 32'h8);
      tick();
    end
    check("s1_drain", 64'(sb.size()), 64'd0);

    // Grant gap in cycle 2.
    do_reset();
    sb.push_back(mk(32'h0));
    for (int c = 0; c <= 7; c++) begin
      bus.mem_grant_i = (c != 2);
      @(negedge dclk);
      if (c == 2) chk_bus("s2_c2", 1'b1, 32'h2);
      if (c == 3) chk_bus("s2_c3", 1'b1, 32'h2);
      if (c == 4) chk_bus("s2_c4", 1'b1, 32'h3);
      if (c == 5) check("s2_v5", 64'(bus.inst_valid_o), 64'd0);
      if (c == 6) check("s2_v6", 64'(bus.inst_valid_o), 64'd1);
      if (c == 7) chk_bus("s2_c7", 1'b1, 32'h4);
      tick();
    end
    bus.mem_grant_i = 1'b1;
    check("s2_drain", 64'(sb.size()), 64'd0);

    // Redirect in cycle 2 to a misaligned target.
    do_reset();
    sb.push_back(mk(32'h104));
    for (int c = 0; c <= 9; c++) begin
      br_en_i     = (c == 2);
      br_target_i = (c == 2) ? 32'h0000_0106 : 32'h0;
      @(negedge dclk);
      if (c == 3) chk_bus("s3_c3", 1'b1, 32'h104);
      if (c == 7) check("s3_v7", 64'(bus.inst_valid_o), 64'd0);
      if (c == 8) check("s3_v8", 64'(bus.inst_valid_o), 64'd1);
      if (c == 9) chk_bus("s3_c9", 1'b1, 32'h108);
      tick();
    end
    br_en_i = 1'b0;
    check("s3_drain", 64'(sb.size()), 64'd0);

    // rdy low in cycles 1-3; a redirect during that window must be ignored.
    do_reset();
    sb.push_back(mk(32'h0));
    for (int c = 0; c <= 9; c++) begin
      rdy         = !(c >= 1 && c <= 3);
      br_en_i     = (c == 2);
      br_target_i = (c == 2) ? 32'h0000_0200 : 32'h0;
      @(negedge dclk);
      if (c >= 1 && c <= 3) chk_bus("s4_frozen", 1'b0, 32'h0);
      if (c == 4) chk_bus("s4_c4", 1'b1, 32'h1);
      if (c == 6) chk_bus("s4_c6", 1'b1, 32'h3);
      if (c == 7) check("s4_v7", 64'(bus.inst_valid_o), 64'd0);
      if (c == 8) check("s4_v8", 64'(bus.inst_valid_o), 64'd1);
      tick();
    end
    rdy = 1'b1; br_en_i = 1'b0;
    check("s4_drain", 64'(sb.size()), 64'd0);

    // Reset mid-fetch, then reset while an instruction is held under stall.
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_bus("s5_rst_bus", 1'b0, 32'h0);
    check("s5_rst_valid", 64'(bus.inst_valid_o), 64'd0);
    @(posedge dclk);
    #1;
    rst = 1'b0;
    stall_i = 1'b1;
    sb.push_back(mk(32'h0));
    for (int c = 0; c <= 7; c++) begin
      @(negedge dclk);
      if (c == 0) chk_bus("s5_c0", 1'b1, 32'h0);
      if (c == 1) chk_bus("s5_c1", 1'b1, 32'h1);
      if (c == 5) check("s5_v5", 64'(bus.inst_valid_o), 64'd1);
      tick();
    end
    check("s5_held", 64'(bus.inst_valid_o), 64'd1);
    rst = 1'b1;
    #1;
    check("s5_rst_hold", {31'd0, bus.inst_valid_o, bus.inst_o}, 64'd0);
    check("s5_rst_pc", 64'(bus.pc_o), 64'd0);
    @(posedge dclk);
    #1;
    rst = 1'b0;
    stall_i = 1'b0;
    check("s5_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V core, directly upstream of the IF/ID pipeline buffer. Holds the PC, reads each 32-bit instruction as four little-endian bytes over the shared byte-wide memory port, and presents the assembled word with its PC to IF/ID. Accepts branch/jump redirects from EX and stalls from the pipeline controller; stalled or mid-fetch cycles present a bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- dclk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes every register and forces mem_req_o low
- stall_i  in  1  controller stall; high blocks hand-off of a completed instruction
- br_en_i  in  1  redirect request from EX, one-cycle pulse
- br_target_i  in  32  redirect target; bits [1:0] forced to 0
- mem_req_o  out  1  byte read request
- mem_addr_o  out  32  byte address; 0 when mem_req_o low
- mem_grant_i  in  1  arbiter grant; address accepted only in cycles with mem_req_o and mem_grant_i both high
- mem_data_i  in  8  read byte, valid the cycle after its address was accepted
- inst_o  out  32  assembled instruction; 0 whenever inst_valid_o low
- pc_o  out  32  PC of inst_o; 0 whenever inst_valid_o low
- inst_valid_o  out  1  inst_o/pc_o hold a complete instruction

## Operation
- State: pc (32), issue_cnt (0..4), recv_cnt (0..4), pending (1), byte buffer (32), FSM {FETCH, HOLD}.
- Reset: pc=RESET_PC, FETCH, counts 0, pending 0; all outputs 0.
- rdy low: nothing changes, inputs ignored (EX holds br_en_i until rdy returns).
- FETCH: mem_req_o = (issue_cnt<4); mem_addr_o = pc+issue_cnt. Accepted issue: issue_cnt+1, pending<=1; else pending<=0.
- Capture: when pending is 1, mem_data_i goes to byte recv_cnt (byte 0 → bits [7:0], byte 3 → [31:24]); recv_cnt+1.
- Capture of byte 3: go HOLD, inst_valid_o<=1, inst_o<=assembled word, pc_o<=pc.
- HOLD: mem_req_o 0. stall_i low: pc<=pc+4 (mod 2^32), counts cleared, valid<=0, back to FETCH. stall_i high: outputs held.
- Redirect (br_en_i high, rdy high), any state: pc<=br_target_i & ~3, counts and pending cleared, valid<=0, FETCH. Byte returning next cycle for the aborted fetch is discarded (pending 0).
- Priorities: rst > rdy low > redirect > HOLD hand-off / FETCH progress. Redirect in the capture cycle of byte 3 or in the hand-off cycle drops that instruction.
- Grant gaps: no issue in that cycle; an in-flight byte is still captured; issuing resumes at the same address.

## Timing
- With grant continuously high, reset released before cycle 0: addresses pc..pc+3 in cycles 0–3, bytes captured at ends of cycles 1–4, inst_valid_o high from cycle 5.
- Without stall: next fetch issues at cycle 6, so throughput is 1 instruction per 6 cycles. Each grant-low cycle adds one cycle.
- Redirect in cycle r: first target address issued in cycle r+1.
- All outputs registered except mem_req_o/mem_addr_o (decoded from registered state and rdy).

## Structure
- Shared macro.vh supplies `Enable`/`Disable`/`ZeroWord`. FSM state encodings go in a shared header as macros so IF/ID and the controller can reference them.
- Single flat module; no sub-module warranted.

## Test plan
- Reset with RESET_PC=0, memory bytes 0..3 = 13,05,00,00, grant always 1 -> addresses 0,1,2,3 in cycles 0–3; cycle 5: inst_o=32'h0000_0513, pc_o=0, valid=1.
- stall_i high for cycles 5–8 -> outputs held, mem_req_o 0. Release at cycle 9 -> addr 4 issued in cycle 10.
- grant low in cycle 2 only -> address 2 repeated in cycle 3; byte 1 still captured in cycle 2; valid from cycle 6.
- br_en_i with target 32'h0000_0106 in cycle 2 -> valid never rises for PC 0; byte 1 discarded; cycle 3 mem_addr_o=32'h104; instruction at 0x104 valid at cycle 8.
- rdy low for cycles 1–3 -> registers frozen, mem_req_o 0. Fetch resumes at address 1 in cycle 4.
- rst asserted mid-fetch (cycle 2) -> outputs 0 immediately. After release, fetch restarts at RESET_PC with counts 0.
